// File: rtl/spi_reg_master.sv
// SPI frame master for the raybox register/vector ports: shifts a 4-bit command followed by
// 0..24 payload bits out in SPI mode 0, then holds chip select high for a fixed gap before
// reporting completion.
module spi_reg_master #(
    parameter int unsigned HALF_PER = 2,
    parameter int unsigned GAP      = 4
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_start,
    input  logic [3:0]  i_cmd,
    input  logic [23:0] i_data,
    input  logic [4:0]  i_len,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_csb,
    output logic        o_sclk,
    output logic        o_mosi
);

    localparam logic [7:0] HalfLoad = 8'(HALF_PER - 1);
    localparam logic [7:0] GapLoad  = 8'(GAP - 1);
    localparam logic [4:0] MaxLen   = 5'd24;

    typedef enum logic [2:0] {
        StIdle,
        StLead,
        StHigh,
        StLow,
        StTrail,
        StGap
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  hcnt_q, hcnt_d;     // cycles left in the current half-period
    logic [4:0]  bcnt_q, bcnt_d;     // frame bits left, including the one on o_mosi
    logic [7:0]  gcnt_q, gcnt_d;     // cycles left in the post-frame gap
    logic [27:0] shreg_q, shreg_d;   // frame, MSB is the bit currently on o_mosi
    logic        csb_q, csb_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [4:0]  len_clamped;
    logic [23:0] data_aligned;
    logic [27:0] frame_load;

    // Clamp the payload length and left-align the payload so the frame always leaves from bit 27.
    always_comb begin
        len_clamped  = (i_len > MaxLen) ? MaxLen : i_len;
        data_aligned = i_data << (MaxLen - len_clamped);
        frame_load   = {i_cmd, data_aligned};
    end

    // Next-state and registered-output computation for the frame sequencer.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        bcnt_d  = bcnt_q;
        gcnt_d  = gcnt_q;
        shreg_d = shreg_q;
        csb_d   = csb_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d = StLead;
                    hcnt_d  = HalfLoad;
                    bcnt_d  = 5'd4 + len_clamped;
                    shreg_d = frame_load;
                    csb_d   = 1'b0;
                    sclk_d  = 1'b0;
                    mosi_d  = frame_load[27];
                    busy_d  = 1'b1;
                end
            end

            StLead: begin
                if (hcnt_q == 8'd0) begin
                    state_d = StHigh;
                    hcnt_d  = HalfLoad;
                    sclk_d  = 1'b1;
                end else begin
                    hcnt_d = hcnt_q - 8'd1;
                end
            end

            StHigh: begin
                if (hcnt_q == 8'd0) begin
                    sclk_d = 1'b0;
                    hcnt_d = HalfLoad;
                    if (bcnt_q == 5'd1) begin
                        state_d = StTrail;
                    end else begin
                        // Next bit goes out together with the falling edge, never on a rise.
                        state_d = StLow;
                        shreg_d = {shreg_q[26:0], 1'b0};
                        mosi_d  = shreg_q[26];
                        bcnt_d  = bcnt_q - 5'd1;
                    end
                end else begin
                    hcnt_d = hcnt_q - 8'd1;
                end
            end

            StLow: begin
                if (hcnt_q == 8'd0) begin
                    state_d = StHigh;
                    hcnt_d  = HalfLoad;
                    sclk_d  = 1'b1;
                end else begin
                    hcnt_d = hcnt_q - 8'd1;
                end
            end

            StTrail: begin
                if (hcnt_q == 8'd0) begin
                    state_d = StGap;
                    csb_d   = 1'b1;
                    mosi_d  = 1'b0;
                    gcnt_d  = GapLoad;
                    // A one-cycle gap is also its own final cycle.
                    if (GapLoad == 8'd0) begin
                        done_d = 1'b1;
                        busy_d = 1'b0;
                    end
                end else begin
                    hcnt_d = hcnt_q - 8'd1;
                end
            end

            StGap: begin
                if (gcnt_q == 8'd0) begin
                    state_d = StIdle;
                end else begin
                    gcnt_d = gcnt_q - 8'd1;
                    if (gcnt_q == 8'd1) begin
                        done_d = 1'b1;
                        busy_d = 1'b0;
                    end
                end
            end

            default: begin
                state_d = StIdle;
                csb_d   = 1'b1;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in flight without a done pulse.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= StIdle;
            hcnt_q  <= 8'd0;
            bcnt_q  <= 5'd0;
            gcnt_q  <= 8'd0;
            shreg_q <= 28'd0;
            csb_q   <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            bcnt_q  <= bcnt_d;
            gcnt_q  <= gcnt_d;
            shreg_q <= shreg_d;
            csb_q   <= csb_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_csb  = csb_q;
    assign o_sclk = sclk_q;
    assign o_mosi = mosi_q;

endmodule
